// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one async-FIFO write port among NREQ valid/ready requesters.
// A grant lasts up to BURST accepted beats; wfull blocks the write combinationally in the same cycle.
module fifo_wr_arb #(
  parameter  int NREQ  = 4,
  parameter  int DSIZE = 8,
  parameter  int BURST = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  gnt_vld,
  output logic [IDW-1:0]        gnt_id
);

  localparam logic [0:0]     S_IDLE    = 1'b0;
  localparam logic [0:0]     S_GRANT   = 1'b1;
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NREQ - 1);
  localparam logic [3:0]     BCNT_LAST = 4'(BURST - 1);

  logic [0:0]     state_q,   state_d;
  logic [IDW-1:0] gnt_id_q,  gnt_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [3:0]     bcnt_q,    bcnt_d;

  logic           accept;
  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] cand;
  logic [DSIZE-1:0] req_data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_data_a[g] = req_data[g*DSIZE +: DSIZE];
  end

  // Search starts one past the last served requester and wraps at NREQ-1.
  // NOTE: every always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    cand     = last_id_q;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  assign gnt_vld = (state_q == S_GRANT);
  assign gnt_id  = gnt_id_q;

  // Write-port steering; wfull reaches winc and req_ready with no register in between.
  always_comb begin
    accept    = 1'b0;
    winc      = 1'b0;
    req_ready = '0;
    wdata     = '0;
    if (state_q == S_GRANT) begin
      accept              = req_valid[gnt_id_q] & ~wfull;
      winc                = accept;
      req_ready[gnt_id_q] = ~wfull;
      wdata               = req_data_a[gnt_id_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    bcnt_d    = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d  = S_GRANT;
          gnt_id_d = pick_id;
          bcnt_d   = '0;
        end
      end
      default: begin
        if (accept && (bcnt_q == BCNT_LAST)) begin
          state_d   = S_IDLE;
          last_id_d = gnt_id_q;
        end else if (accept) begin
          bcnt_d = bcnt_q + 4'd1;
        end else if (!req_valid[gnt_id_q]) begin
          // Requester released early; a wfull stall with valid held keeps the grant.
          state_d   = S_IDLE;
          last_id_d = gnt_id_q;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= S_IDLE;
      gnt_id_q  <= '0;
      last_id_q <= LAST_IDX;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      bcnt_q    <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios on a BURST=4 instance, then random traffic on
// BURST=4, BURST=1 and BURST=16 instances checked against per-requester expected-beat queues.
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int NI    = 3;

  typedef logic [DSIZE-1:0] data_t;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       rv     [NI];
  logic [NREQ*DSIZE-1:0] rd     [NI];
  logic [NREQ-1:0]       rr     [NI];
  logic                  wf     [NI];
  logic                  winc_o [NI];
  data_t                 wd     [NI];
  logic                  gv     [NI];
  logic [1:0]            gid    [NI];

  int    n_pass;
  int    n_total;
  int    seq    [NI][NREQ];
  int    budget [NREQ];
  data_t ord_q  [$];
  data_t exp_q  [NI*NREQ][$];

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(4)) u_dut_b4 (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
    .wfull(wf[0]), .winc(winc_o[0]), .wdata(wd[0]), .gnt_vld(gv[0]), .gnt_id(gid[0]));

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(1)) u_dut_b1 (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
    .wfull(wf[1]), .winc(winc_o[1]), .wdata(wd[1]), .gnt_vld(gv[1]), .gnt_id(gid[1]));

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(16)) u_dut_b16 (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(rv[2]), .req_data(rd[2]), .req_ready(rr[2]),
    .wfull(wf[2]), .winc(winc_o[2]), .wdata(wd[2]), .gnt_vld(gv[2]), .gnt_id(gid[2]));

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Beat payload carries the requester id in the top bits and a sequence number below.
  function automatic data_t beat(input int i, input int s);
    return {i[2:0], s[4:0]};
  endfunction

  function automatic int burst_of(input int j);
    return (j == 0) ? 4 : (j == 1) ? 1 : 16;
  endfunction

  task automatic do_reset();
    wrst_n = 1'b0;
    for (int j = 0; j < NI; j++) begin
      rv[j] = '0;
      rd[j] = '0;
      wf[j] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        seq[j][i] = 0;
        exp_q[j*NREQ+i].delete();
      end
    end
    for (int i = 0; i < NREQ; i++) budget[i] = 0;
    ord_q.delete();
    repeat (2) @(posedge wclk);
    #1;
  endtask

  // Directed requester model on instance 0: valid while budget remains, data from sequence.
  task automatic set_reqs0();
    for (int i = 0; i < NREQ; i++) begin
      rv[0][i] = (budget[i] > 0);
      rd[0][i*DSIZE +: DSIZE] = beat(i, seq[0][i]);
    end
  endtask

  task automatic advance0();
    for (int i = 0; i < NREQ; i++) begin
      if (rr[0][i] && rv[0][i]) begin
        seq[0][i]++;
        budget[i]--;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NREQ; i++) budget[i] = 4;
    set_reqs0();
    @(negedge wclk);
    n_total++; if (gv[0] !== 1'b0) $display("FAIL reset_gnt_vld: got %b want 0", gv[0]); else n_pass++;
    n_total++; if (gid[0] !== 2'd0) $display("FAIL reset_gnt_id: got %0d want 0", gid[0]); else n_pass++;
    n_total++; if (winc_o[0] !== 1'b0) $display("FAIL reset_winc: got %b want 0", winc_o[0]); else n_pass++;
    n_total++; if (rr[0] !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", rr[0]); else n_pass++;
    n_total++; if (wd[0] !== 8'h00) $display("FAIL reset_wdata: got %h want 00", wd[0]); else n_pass++;
  endtask

  task automatic test_round_robin();
    data_t e;
    int    writes;
    do_reset();
    for (int i = 0; i < NREQ; i++) budget[i] = 100;
    for (int g = 0; g < NREQ; g++)
      for (int b = 0; b < 4; b++) ord_q.push_back(beat(g, b));
    ord_q.push_back(beat(0, 4));
    set_reqs0();
    wrst_n = 1'b1;
    writes = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge wclk);
      if (c == 0) begin
        n_total++;
        if (gv[0] !== 1'b0) $display("FAIL rr_first_idle: gnt_vld=%b want 0", gv[0]); else n_pass++;
      end
      if (c == 1 || c == 21) begin
        n_total++;
        if ({gv[0], gid[0]} !== {1'b1, 2'd0})
          $display("FAIL rr_grant0 c=%0d: gnt_vld=%b gnt_id=%0d want 1/0", c, gv[0], gid[0]);
        else n_pass++;
      end
      if (winc_o[0]) begin
        if (c < 20) writes++;
        n_total++;
        if (ord_q.size() == 0) $display("FAIL rr_data c=%0d: unexpected write %h", c, wd[0]);
        else begin
          e = ord_q.pop_front();
          if (wd[0] !== e) $display("FAIL rr_data c=%0d: got %h want %h", c, wd[0], e); else n_pass++;
        end
      end
      advance0();
      @(posedge wclk); #1;
      set_reqs0();
    end
    n_total++; if (writes !== 16) $display("FAIL rr_write_count: got %0d want 16", writes); else n_pass++;
    n_total++; if (ord_q.size() !== 0) $display("FAIL rr_missing: %0d beats not written", ord_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    data_t e;
    int    writes;
    do_reset();
    budget[2] = 4;
    for (int b = 0; b < 4; b++) ord_q.push_back(beat(2, b));
    set_reqs0();
    wrst_n = 1'b1;
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      if (c >= 3 && c <= 5) begin
        n_total++;
        if ({gv[0], gid[0], winc_o[0], rr[0]} !== {1'b1, 2'd2, 1'b0, 4'b0000})
          $display("FAIL bp_stall c=%0d: gnt_vld=%b gnt_id=%0d winc=%b ready=%b want 1/2/0/0000",
                   c, gv[0], gid[0], winc_o[0], rr[0]);
        else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if (gv[0] !== 1'b0) $display("FAIL bp_release: gnt_vld=%b want 0", gv[0]); else n_pass++;
      end
      if (winc_o[0]) begin
        writes++;
        n_total++;
        if (ord_q.size() == 0) $display("FAIL bp_data c=%0d: unexpected write %h", c, wd[0]);
        else begin
          e = ord_q.pop_front();
          if (wd[0] !== e) $display("FAIL bp_data c=%0d: got %h want %h", c, wd[0], e); else n_pass++;
        end
      end
      advance0();
      @(posedge wclk); #1;
      wf[0] = (c + 1 >= 3) && (c + 1 <= 5);
      set_reqs0();
    end
    n_total++; if (writes !== 4) $display("FAIL bp_write_count: got %0d want 4", writes); else n_pass++;
  endtask

  task automatic test_early_release();
    data_t e;
    int    writes;
    do_reset();
    budget[1] = 2;
    ord_q.push_back(beat(1, 0));
    ord_q.push_back(beat(1, 1));
    for (int b = 0; b < 4; b++) ord_q.push_back(beat(3, b));
    for (int b = 0; b < 4; b++) ord_q.push_back(beat(0, b));
    set_reqs0();
    wrst_n = 1'b1;
    writes = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge wclk);
      if (c == 3) begin
        n_total++;
        if ({gv[0], gid[0], winc_o[0]} !== {1'b1, 2'd1, 1'b0})
          $display("FAIL er_drop: gnt_vld=%b gnt_id=%0d winc=%b want 1/1/0", gv[0], gid[0], winc_o[0]);
        else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if (gv[0] !== 1'b0) $display("FAIL er_idle: gnt_vld=%b want 0", gv[0]); else n_pass++;
      end
      if (c == 5) begin
        n_total++;
        if ({gv[0], gid[0]} !== {1'b1, 2'd3})
          $display("FAIL er_next: gnt_vld=%b gnt_id=%0d want 1/3", gv[0], gid[0]);
        else n_pass++;
      end
      if (winc_o[0]) begin
        writes++;
        n_total++;
        if (ord_q.size() == 0) $display("FAIL er_data c=%0d: unexpected write %h", c, wd[0]);
        else begin
          e = ord_q.pop_front();
          if (wd[0] !== e) $display("FAIL er_data c=%0d: got %h want %h", c, wd[0], e); else n_pass++;
        end
      end
      advance0();
      @(posedge wclk); #1;
      if (c == 0) begin
        budget[0] = 4;
        budget[3] = 4;
      end
      set_reqs0();
    end
    n_total++; if (writes !== 10) $display("FAIL er_write_count: got %0d want 10", writes); else n_pass++;
  endtask

  task automatic test_wrap();
    data_t e;
    int    writes;
    do_reset();
    budget[3] = 8;
    for (int b = 0; b < 4; b++) ord_q.push_back(beat(3, b));
    for (int b = 0; b < 4; b++) ord_q.push_back(beat(0, b));
    for (int b = 4; b < 8; b++) ord_q.push_back(beat(3, b));
    set_reqs0();
    wrst_n = 1'b1;
    writes = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge wclk);
      if (c == 6 || c == 11) begin
        n_total++;
        if ({gv[0], gid[0]} !== {1'b1, (c == 6) ? 2'd0 : 2'd3})
          $display("FAIL wrap_grant c=%0d: gnt_vld=%b gnt_id=%0d want 1/%0d", c, gv[0], gid[0], (c == 6) ? 0 : 3);
        else n_pass++;
      end
      if (winc_o[0]) begin
        writes++;
        n_total++;
        if (ord_q.size() == 0) $display("FAIL wrap_data c=%0d: unexpected write %h", c, wd[0]);
        else begin
          e = ord_q.pop_front();
          if (wd[0] !== e) $display("FAIL wrap_data c=%0d: got %h want %h", c, wd[0], e); else n_pass++;
        end
      end
      advance0();
      @(posedge wclk); #1;
      if (c == 0) budget[0] = 4;
      set_reqs0();
    end
    n_total++; if (writes !== 12) $display("FAIL wrap_write_count: got %0d want 12", writes); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    data_t e;
    do_reset();
    budget[0] = 100;
    budget[1] = 100;
    ord_q.push_back(beat(0, 0));
    set_reqs0();
    wrst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      if (winc_o[0] && c < 2) begin
        n_total++;
        if (ord_q.size() == 0) $display("FAIL rmb_data c=%0d: unexpected write %h", c, wd[0]);
        else begin
          e = ord_q.pop_front();
          if (wd[0] !== e) $display("FAIL rmb_data c=%0d: got %h want %h", c, wd[0], e); else n_pass++;
        end
      end
      if (c == 2) begin
        n_total++;
        if (winc_o[0] !== 1'b1) $display("FAIL rmb_second_beat: winc=%b want 1", winc_o[0]); else n_pass++;
      end
      if (c < 2) begin
        advance0();
        @(posedge wclk); #1;
        set_reqs0();
      end
    end
    #1 wrst_n = 1'b0;
    #1;
    n_total++;
    if ({winc_o[0], gv[0], rr[0]} !== 6'b0)
      $display("FAIL rmb_async: winc=%b gnt_vld=%b ready=%b want 0/0/0000", winc_o[0], gv[0], rr[0]);
    else n_pass++;
    n_total++; if (wd[0] !== 8'h00) $display("FAIL rmb_wdata: got %h want 00", wd[0]); else n_pass++;
    @(posedge wclk); #1;
    ord_q.push_back(beat(0, 1));
    wrst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk);
      if (c == 1) begin
        n_total++;
        if ({gv[0], gid[0], winc_o[0]} !== {1'b1, 2'd0, 1'b1})
          $display("FAIL rmb_regrant: gnt_vld=%b gnt_id=%0d winc=%b want 1/0/1", gv[0], gid[0], winc_o[0]);
        else n_pass++;
        if (winc_o[0]) begin
          n_total++;
          if (ord_q.size() == 0) $display("FAIL rmb_data_after: unexpected write %h", wd[0]);
          else begin
            e = ord_q.pop_front();
            if (wd[0] !== e) $display("FAIL rmb_data_after: got %h want %h", wd[0], e); else n_pass++;
          end
        end
      end
      advance0();
      @(posedge wclk); #1;
      set_reqs0();
    end
    n_total++; if (ord_q.size() !== 0) $display("FAIL rmb_missing: %0d beats not written", ord_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic [NREQ-1:0]       hs;
    logic [NREQ-1:0]       nrv [NI];
    logic [NREQ*DSIZE-1:0] nrd [NI];
    logic                  nwf [NI];
    int    waitc    [NI*NREQ];
    int    max_wait [NI];
    int    wr_cnt   [NI];
    int    r;
    int    k;
    data_t e;
    do_reset();
    for (int j = 0; j < NI; j++) begin
      max_wait[j] = 0;
      wr_cnt[j]   = 0;
      for (int i = 0; i < NREQ; i++) waitc[j*NREQ+i] = 0;
    end
    wrst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge wclk);
      for (int j = 0; j < NI; j++) begin
        hs = rr[j] & rv[j];
        n_total++;
        if ((|hs) !== winc_o[j])
          $display("FAIL rnd_handshake b%0d c=%0d: winc=%b ready&valid=%b", burst_of(j), c, winc_o[j], hs);
        else n_pass++;
        if (winc_o[j]) begin
          wr_cnt[j]++;
          n_total++;
          if (wf[j] !== 1'b0) $display("FAIL rnd_write_full b%0d c=%0d: winc=1 with wfull=1", burst_of(j), c);
          else n_pass++;
          r = -1;
          for (int i = 0; i < NREQ; i++) if (hs[i]) r = i;
          n_total++;
          if (!$onehot(hs) || exp_q[j*NREQ+r].size() == 0)
            $display("FAIL rnd_data b%0d c=%0d: write %h with ready&valid=%b and no expected beat",
                     burst_of(j), c, wd[j], hs);
          else begin
            e = exp_q[j*NREQ+r].pop_front();
            if (wd[j] !== e) $display("FAIL rnd_data b%0d c=%0d: got %h want %h", burst_of(j), c, wd[j], e);
            else n_pass++;
          end
        end
        nrv[j] = rv[j];
        nrd[j] = rd[j];
        for (int i = 0; i < NREQ; i++) begin
          k = j*NREQ + i;
          if (hs[i]) begin
            waitc[k] = 0;
            seq[j][i]++;
            nrv[j][i] = 1'b0;
          end else if (rv[j][i] && !wf[j]) begin
            waitc[k]++;
            if (waitc[k] > max_wait[j]) max_wait[j] = waitc[k];
          end
          if (!nrv[j][i] && $urandom_range(0, 9) < 6) begin
            nrv[j][i] = 1'b1;
            nrd[j][i*DSIZE +: DSIZE] = beat(i, seq[j][i]);
            exp_q[k].push_back(beat(i, seq[j][i]));
          end
        end
        nwf[j] = ($urandom_range(0, 3) == 0);
      end
      @(posedge wclk); #1;
      for (int j = 0; j < NI; j++) begin
        rv[j] = nrv[j];
        rd[j] = nrd[j];
        wf[j] = nwf[j];
      end
    end
    @(negedge wclk);
    for (int j = 0; j < NI; j++) begin
      n_total++;
      if (max_wait[j] > (NREQ-1)*(burst_of(j)+1)+1)
        $display("FAIL rnd_wait b%0d: max wait %0d exceeds %0d", burst_of(j), max_wait[j], (NREQ-1)*(burst_of(j)+1)+1);
      else n_pass++;
      n_total++;
      if (wr_cnt[j] < 1000) $display("FAIL rnd_progress b%0d: only %0d writes", burst_of(j), wr_cnt[j]);
      else n_pass++;
      for (int i = 0; i < NREQ; i++) begin
        n_total++;
        if (exp_q[j*NREQ+i].size() !== (rv[j][i] ? 1 : 0))
          $display("FAIL rnd_lost b%0d req%0d: %0d beats outstanding, valid=%b",
                   burst_of(j), i, exp_q[j*NREQ+i].size(), rv[j][i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO (`winc`/`wdata`/`wfull`, `wclk` domain) among `NREQ` independent requesters. Each requester presents a valid/ready stream; the arbiter grants one requester at a time for a burst of up to `BURST` beats and steers its data onto the FIFO write port. It never writes while `wfull` is high. The block sits entirely in the write clock domain, in front of the FIFO top level.

## Interface

Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `DSIZE`, 8: data width; must match the FIFO `DSIZE`.
- `BURST`, 4: maximum accepted beats per grant; legal range 1..16.
- `IDW`, derived `$clog2(NREQ)`: grant-id width (localparam).

Ports:
- `wclk`  in  1  write clock; single clock for the block.
- `wrst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i has a beat available.
- `req_data`  in  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE].
- `req_ready`  out  NREQ  bit i: requester i's beat is accepted this cycle.
- `wfull`  in  1  FIFO full flag.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `gnt_vld`  out  1  a grant is active (state GRANT).
- `gnt_id`  out  IDW  index of the granted requester.

## Operation

- **States:** IDLE and GRANT. Registered state: `gnt_id`, round-robin pointer `last_id`, and a 4-bit beat counter `bcnt`.
- **IDLE:**
  - If any `req_valid` is set, select the first set index searching from `last_id+1` upward, modulo `NREQ`.
  - Load `gnt_id` with that index, clear `bcnt`, and enter GRANT on the next edge.
  - If no request is present, stay in IDLE.
- **GRANT outputs (combinational from registered state and inputs):**
  - `accept = req_valid[gnt_id] & ~wfull`.
  - `winc = accept`.
  - `req_ready[gnt_id] = ~wfull`. All other `req_ready` bits are 0.
  - `wdata = req_data[gnt_id]`.
- **GRANT transitions:**
  - If `accept` and `bcnt == BURST-1`: go to IDLE and set `last_id <= gnt_id`.
  - Else if `accept`: `bcnt <= bcnt+1`.
  - Else if `~req_valid[gnt_id]`: go to IDLE and set `last_id <= gnt_id`. The requester released early.
  - Else (`wfull` with valid held): stay and hold the grant. There is no timeout.
- **IDLE outputs:** `winc = 0`, `req_ready = 0`, `wdata = 0`.
- **Protocol:** requesters must hold `req_valid` and `req_data` stable until `req_ready`. The arbiter never drops an accepted beat and never writes when `wfull` is 1.
- **Requester dropping valid:** if the granted requester deasserts `req_valid` mid-burst, the grant is released. The burst is not resumed.

## Timing

- **Reset values:**
  - state IDLE, `gnt_vld = 0`, `gnt_id = 0`, `bcnt = 0`, `last_id = NREQ-1` (so requester 0 wins first).
  - `winc = 0`, `req_ready = 0`, `wdata = 0`.
- **Reset assertion:** asynchronous. Outputs go to reset values immediately, even mid-burst. A beat that is not accepted before the reset edge is lost to the FIFO.
- **Arbitration latency:** one cycle. A request seen in IDLE at edge N gives `gnt_vld = 1` after edge N, and the first `winc` can occur in cycle N+1.
- **Throughput:**
  - One IDLE cycle is inserted between consecutive grants.
  - Peak throughput is `BURST/(BURST+1)` beats per cycle with no backpressure.
  - With `NREQ` saturating requesters, each receives `BURST` beats per `NREQ*(BURST+1)` cycles.
- **`wfull`:** zero-cycle path to `winc`/`req_ready`. Asserting `wfull` in a cycle blocks the write in that same cycle. `bcnt` does not advance while `wfull` is high.
- **Simultaneous events:** if `wfull` is high while the granted requester drops valid, the grant is released (the valid-low rule applies).
- **Wrap-around:** the round-robin search wraps from `NREQ-1` to 0.
- **Single requester:** one requester alone receives back-to-back grants, with one IDLE cycle between them.

## Test plan

- **Reset and first grant:** after reset, all four requesters are valid from cycle 0 → grants in order 0,1,2,3,0. Each grant yields 4 `winc` pulses followed by 1 idle cycle, for 16 writes in 20 cycles.
- **Backpressure:** requester 2 alone, `wfull` high for 3 cycles mid-burst → `winc` and `req_ready[2]` are 0 in those cycles. `gnt_id` stays 2. Exactly 4 beats are written; FIFO contents match the sent order.
- **Early release:** requester 1 drops valid after 2 beats, requester 3 is valid → grant moves to 3 after one IDLE cycle. `last_id = 1`, so requester 3 wins even if requester 0 is also valid.
- **Wrap-around:** `last_id = 3`; requesters 0 and 3 are valid → 0 is granted, then 3.
- **Reset mid-burst:** assert `wrst_n = 0` during the 2nd beat of a grant → `winc`, `gnt_vld` and `req_ready` drop before the next `wclk` edge. After release, requester 0 is granted first.
- **Scoreboard:** random valid and `wfull` traffic for 10k cycles with `BURST = 1` and `BURST = 16` → no write while `wfull`, no lost or duplicated beats, and no requester waits longer than `(NREQ-1)*(BURST+1)+1` cycles once `wfull` is low.
